// File: rtl/etapa_mem.sv
// Memory stage: ALU pass-through in 1 cycle, or a 32-bit load/store as four serial byte transfers, stalling upstream meanwhile.
// Optional per-byte ack timeout with sticky mem_err when ETAPA_MEM_TIMEOUT_EN is defined.
module etapa_mem #(
   parameter int TIMEOUT = 15
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        in_valid,
   input  logic        mem_read,
   input  logic        mem_write,
   input  logic        reg_write,
   input  logic [31:0] alu_result,
   input  logic [31:0] data1_in,
   input  logic [2:0]  dir_dest_in,
   input  logic [7:0]  inmediate_in,
   output logic        stall,
   output logic        mem_req,
   output logic        mem_we,
   output logic [9:0]  mem_addr,
   output logic [7:0]  mem_wdata,
   input  logic [7:0]  mem_rdata,
   input  logic        mem_ack,
   output logic        wb_valid,
   output logic        wb_we,
   output logic [31:0] wb_data,
   output logic [2:0]  wb_dest
`ifdef ETAPA_MEM_TIMEOUT_EN
   ,
   output logic        mem_err
`endif
);

   typedef enum logic {IDLE, XFER} state_t;

   state_t      state_q, state_d;
   logic [1:0]  lane_q, lane_d;
   logic        is_store_q, is_store_d;
   logic        rw_q, rw_d;
   logic [2:0]  dest_q, dest_d;
   logic [7:0]  addr_q, addr_d;
   logic [31:0] sdata_q, sdata_d;
   logic [31:0] ldbuf_q, ldbuf_d;
   logic        wb_valid_q, wb_valid_d;
   logic        wb_we_q, wb_we_d;
   logic [31:0] wb_data_q, wb_data_d;
   logic [2:0]  wb_dest_q, wb_dest_d;
`ifdef ETAPA_MEM_TIMEOUT_EN
   localparam int CW = $clog2(TIMEOUT + 1);
   logic [CW-1:0] cnt_q, cnt_d;
   logic          err_q, err_d;
`endif

   always_comb begin
      state_d    = state_q;
      lane_d     = lane_q;
      is_store_d = is_store_q;
      rw_d       = rw_q;
      dest_d     = dest_q;
      addr_d     = addr_q;
      sdata_d    = sdata_q;
      ldbuf_d    = ldbuf_q;
      wb_valid_d = 1'b0;
      wb_we_d    = 1'b0;
      wb_data_d  = wb_data_q;
      wb_dest_d  = wb_dest_q;
`ifdef ETAPA_MEM_TIMEOUT_EN
      cnt_d      = cnt_q;
      err_d      = err_q;
`endif
      case (state_q)
         IDLE: begin
            if (in_valid) begin
               if (mem_read || mem_write) begin
                  state_d    = XFER;
                  lane_d     = 2'd0;
                  is_store_d = mem_write;
                  rw_d       = reg_write;
                  dest_d     = dir_dest_in;
                  addr_d     = inmediate_in;
                  sdata_d    = data1_in;
                  ldbuf_d    = 32'd0;
`ifdef ETAPA_MEM_TIMEOUT_EN
                  cnt_d      = '0;
`endif
               end else begin
                  wb_valid_d = 1'b1;
                  wb_we_d    = reg_write;
                  wb_data_d  = alu_result;
                  wb_dest_d  = dir_dest_in;
               end
            end
         end
         XFER: begin
            if (mem_ack) begin
               if (!is_store_q) ldbuf_d[{lane_q, 3'b000} +: 8] = mem_rdata;
`ifdef ETAPA_MEM_TIMEOUT_EN
               cnt_d = '0;
`endif
               if (lane_q == 2'd3) begin
                  state_d    = IDLE;
                  wb_valid_d = 1'b1;
                  wb_we_d    = !is_store_q && rw_q;
                  // Top byte bypasses the buffer since it arrives this cycle.
                  wb_data_d  = is_store_q ? 32'd0 : {mem_rdata, ldbuf_q[23:0]};
                  wb_dest_d  = dest_q;
               end else begin
                  lane_d = lane_q + 2'd1;
               end
            end
`ifdef ETAPA_MEM_TIMEOUT_EN
            else if (cnt_q == CW'(TIMEOUT - 1)) begin
               state_d = IDLE;
               err_d   = 1'b1;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
`endif
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         lane_q     <= 2'd0;
         is_store_q <= 1'b0;
         rw_q       <= 1'b0;
         dest_q     <= 3'd0;
         addr_q     <= 8'd0;
         sdata_q    <= 32'd0;
         ldbuf_q    <= 32'd0;
         wb_valid_q <= 1'b0;
         wb_we_q    <= 1'b0;
         wb_data_q  <= 32'd0;
         wb_dest_q  <= 3'd0;
`ifdef ETAPA_MEM_TIMEOUT_EN
         cnt_q      <= '0;
         err_q      <= 1'b0;
`endif
      end else begin
         state_q    <= state_d;
         lane_q     <= lane_d;
         is_store_q <= is_store_d;
         rw_q       <= rw_d;
         dest_q     <= dest_d;
         addr_q     <= addr_d;
         sdata_q    <= sdata_d;
         ldbuf_q    <= ldbuf_d;
         wb_valid_q <= wb_valid_d;
         wb_we_q    <= wb_we_d;
         wb_data_q  <= wb_data_d;
         wb_dest_q  <= wb_dest_d;
`ifdef ETAPA_MEM_TIMEOUT_EN
         cnt_q      <= cnt_d;
         err_q      <= err_d;
`endif
      end
   end

   assign stall     = (state_q == XFER);
   assign mem_req   = (state_q == XFER);
   assign mem_we    = (state_q == XFER) && is_store_q;
   assign mem_addr  = (state_q == XFER) ? {addr_q, lane_q} : 10'd0;
   assign mem_wdata = ((state_q == XFER) && is_store_q) ? sdata_q[{lane_q, 3'b000} +: 8] : 8'd0;
   assign wb_valid  = wb_valid_q;
   assign wb_we     = wb_we_q;
   assign wb_data   = wb_data_q;
   assign wb_dest   = wb_dest_q;
`ifdef ETAPA_MEM_TIMEOUT_EN
   assign mem_err   = err_q;
`endif

endmodule
